// File: rtl/inst_queue.sv
// Circular fetch->decode instruction queue with show-ahead head and single-cycle flush.
// Optional performance counters are enabled by defining INST_QUEUE_PERF_EN.
module inst_queue #(
    parameter int DEPTH  = 16,
    // Entry layout (MSB first): pc[31:0], pc_next[31:0], out_inst[31:0], prediction
    parameter int DATA_W = 97,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              branch,
    input  logic              enq,
    input  logic [DATA_W-1:0] enq_data,
    output logic              full,
    input  logic              deq,
    output logic              empty,
    output logic [DATA_W-1:0] if_id_reg,
    output logic [PTR_W:0]    count
`ifdef INST_QUEUE_PERF_EN
    ,
    output logic [31:0]       perf_full_cycles,
    output logic [PTR_W:0]    perf_max_occ
`endif
);

    localparam logic [PTR_W:0] PTR_ONE = 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W:0]    head_q, head_d;
    logic [PTR_W:0]    tail_q, tail_d;
    logic              push_ok;
    logic              pop_ok;

    // Status comes only from registered pointers; the MSB acts as the wrap bit.
    assign empty = (head_q == tail_q);
    assign full  = (head_q[PTR_W-1:0] == tail_q[PTR_W-1:0]) && (head_q[PTR_W] != tail_q[PTR_W]);
    assign count = tail_q - head_q;

    assign if_id_reg = empty ? '0 : mem_q[head_q[PTR_W-1:0]];

    assign push_ok = enq && !full && !branch;
    assign pop_ok  = deq && !empty && !branch;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        if (branch) begin
            head_d = '0;
            tail_d = '0;
        end else begin
            if (push_ok) tail_d = tail_q + PTR_ONE;
            if (pop_ok)  head_d = head_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[tail_q[PTR_W-1:0]] <= enq_data;
    end

`ifdef INST_QUEUE_PERF_EN
    logic [31:0]    full_cyc_q, full_cyc_d;
    logic [PTR_W:0] max_occ_q, max_occ_d;
    logic [PTR_W:0] count_d;

    assign count_d = tail_d - head_d;

    // Stall counter saturates; high-water mark tracks next occupancy so it never trails count.
    always_comb begin
        full_cyc_d = full_cyc_q;
        max_occ_d  = max_occ_q;
        if (full && enq && (full_cyc_q != 32'hFFFF_FFFF)) full_cyc_d = full_cyc_q + 32'd1;
        if (count_d > max_occ_q) max_occ_d = count_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full_cyc_q <= '0;
            max_occ_q  <= '0;
        end else begin
            full_cyc_q <= full_cyc_d;
            max_occ_q  <= max_occ_d;
        end
    end

    assign perf_full_cycles = full_cyc_q;
    assign perf_max_occ     = max_occ_q;
`endif

endmodule
